i2c_pad_filter: RTL
===================

Name: i2c_pad_filter

Overview:
Input-conditioning stage directly upstream of the APB I2C core's scl_pad_i/sda_pad_i inputs. Synchronizes the raw SCL/SDA pad inputs into HCLK and suppresses spikes with a programmable-length digital filter. Derives SCL edge strobes, START/STOP strobes and a bus-busy flag from the filtered lines, which the core's master/slave FSMs consume.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per line (legal range 2..4)
SPK_W, 8, width of the spike-length control and of each filter counter

Ports:
HCLK  input  1  system clock
HRESET  input  1  asynchronous active-high reset
scl_pad_i  input  1  raw SCL from pad (asynchronous)
sda_pad_i  input  1  raw SDA from pad (asynchronous)
filt_en  input  1  1 = spike filter active, 0 = bypass (synchronized only)
spklen  input  SPK_W  minimum stable cycles before a level is accepted; 0 treated as 1
scl_o  output  1  filtered SCL
sda_o  output  1  filtered SDA
scl_rise  output  1  one-cycle strobe, scl_o rose
scl_fall  output  1  one-cycle strobe, scl_o fell
start_det  output  1  one-cycle strobe, START or repeated START
stop_det  output  1  one-cycle strobe, STOP
bus_busy  output  1  high from START until STOP

Behaviour:
- Reset (asynchronous, HRESET=1): all sync flops, scl_o, sda_o and their previous-value registers = 1 (idle bus). Filter counters = 0. scl_rise, scl_fall, start_det, stop_det, bus_busy = 0.
- Synchronizer: SYNC_STAGES flops per line. The sync output reflects a pad change SYNC_STAGES edges after the first sampling edge.
- Filter, per line, with eff = max(spklen,1):
  - sync == out: counter <= 0.
  - sync != out and counter+1 >= eff: out <= sync, counter <= 0.
  - Otherwise: counter++, saturating at all-ones.
- Filter latency: eff edges after the sync output changes. Total pad-to-output latency is SYNC_STAGES+eff edges. A differing level that lasts fewer than eff cycles at the sync output is dropped, and the counter returns to 0.
- spklen change takes effect on the next edge. If the current count is already >= the new eff, out updates on that edge.
- filt_en=0: out <= sync every edge and counters are held at 0. Switching filt_en also applies on the next edge with no glitch beyond the normal update.
- Detection uses registered previous values scl_q and sda_q (updated every edge from scl_o and sda_o). Strobes are registered: each asserts for exactly one cycle, on the edge after the filtered change.
  - scl_rise: scl_o & ~scl_q.
  - scl_fall: ~scl_o & scl_q.
  - start_det: scl_o & scl_q & sda_q & ~sda_o, i.e. SDA falls while SCL is stable high.
  - stop_det: scl_o & scl_q & ~sda_q & sda_o.
- Simultaneous SCL and SDA change in one cycle: no start_det and no stop_det. Only the SCL edge strobe fires.
- bus_busy: set on the same edge start_det asserts, cleared on the same edge stop_det asserts. A repeated START while busy keeps it at 1. start_det and stop_det are mutually exclusive by construction.
- Reset mid-transfer: all outputs return immediately to their reset values. A START is needed to re-enter busy.

Test Plan:
- Reset: hold HRESET=1 with pads at 0 -> scl_o=sda_o=1, all strobes and bus_busy=0. Release -> scl_o/sda_o go to 0 after SYNC_STAGES+1 edges (spklen=1) with one scl_fall strobe.
- Spike suppression: filt_en=1, spklen=5, SDA low for 3 HCLK cycles while SCL high -> sda_o stays 1, no start_det. Repeat with SDA low for 5 cycles -> sda_o falls exactly SYNC_STAGES+5 edges after the pad edge, start_det=1 for one cycle, bus_busy=1 from that edge.
- STOP: from busy with SCL high, raise SDA -> stop_det one cycle, bus_busy=0 on the same edge. With SCL low, raise SDA -> no stop_det, bus_busy stays 1.
- Repeated START: busy, SCL high, SDA 1->0 -> start_det pulses, bus_busy stays 1, no stop_det.
- Bypass and simultaneity: filt_en=0, toggle SCL and SDA on the same pad edge while SCL was high -> both outputs change after SYNC_STAGES+1 edges, scl_fall pulses, no start_det or stop_det. 1-cycle pad glitch propagates to the output. spklen=0 behaves identically to spklen=1.
- Reset mid-transfer: bus_busy=1 with counter at 3 of spklen=8, assert HRESET asynchronously -> bus_busy=0, strobes=0 and scl_o=sda_o=1 without waiting for an HCLK edge.

Source files
------------

// File: rtl/i2c_pad_filter.sv
// i2c_pad_filter: conditions the raw SCL/SDA pad inputs for the I2C core.
// Each line is synchronised into HCLK and then passed through a spike filter
// with a programmable length. SCL edge strobes, START/STOP strobes and a
// bus-busy flag are derived from the filtered lines.
module i2c_pad_filter #(
    parameter int SYNC_STAGES = 2,   // synchronizer depth per line, 2..4
    parameter int SPK_W       = 8    // spike-length / filter-counter width
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             scl_pad_i,
    input  logic             sda_pad_i,
    input  logic             filt_en,
    input  logic [SPK_W-1:0] spklen,
    output logic             scl_o,
    output logic             sda_o,
    output logic             scl_rise,
    output logic             scl_fall,
    output logic             start_det,
    output logic             stop_det,
    output logic             bus_busy
);

    // Line 0 is SCL, line 1 is SDA; both share the same conditioning path.
    logic [1:0]       w_pad;
    logic [1:0]       w_filt;
    logic [SPK_W-1:0] w_eff;

    assign w_pad = {sda_pad_i, scl_pad_i};

    // A spike length of zero behaves exactly like a length of one.
    assign w_eff = (spklen == '0) ? SPK_W'(1) : spklen;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_line
            logic [SYNC_STAGES-1:0] r_sync;
            logic [SPK_W-1:0]       r_cnt;
            logic                   r_out;
            logic                   w_sync;
            logic [SPK_W:0]         w_cnt_inc;

            assign w_sync    = r_sync[SYNC_STAGES-1];
            assign w_cnt_inc = {1'b0, r_cnt} + (SPK_W+1)'(1);
            assign w_filt[gi] = r_out;

            // Synchronizer chain; resets to the idle (high) bus level.
            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad[gi]};
                end
            end

            // Spike filter: a new level is accepted only once it has been
            // seen for eff consecutive edges; shorter excursions are dropped.
            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    r_out <= 1'b1;
                    r_cnt <= '0;
                end else if (!filt_en) begin
                    r_out <= w_sync;
                    r_cnt <= '0;
                end else if (w_sync == r_out) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc >= {1'b0, w_eff}) begin
                    r_out <= w_sync;
                    r_cnt <= '0;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + SPK_W'(1);
                end
            end
        end
    endgenerate

    // Previous filtered values and registered event strobes.
    logic r_scl_q;
    logic r_sda_q;
    logic r_scl_rise;
    logic r_scl_fall;
    logic r_start_det;
    logic r_stop_det;
    logic r_bus_busy;
    logic w_start;
    logic w_stop;

    // START/STOP need SCL high on both sides of the SDA change, so a
    // simultaneous SCL+SDA change never produces either condition.
    assign w_start = w_filt[0] & r_scl_q & r_sda_q & ~w_filt[1];
    assign w_stop  = w_filt[0] & r_scl_q & ~r_sda_q & w_filt[1];

    // Edge/condition detection and bus-busy tracking.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_scl_q     <= 1'b1;
            r_sda_q     <= 1'b1;
            r_scl_rise  <= 1'b0;
            r_scl_fall  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_bus_busy  <= 1'b0;
        end else begin
            r_scl_q     <= w_filt[0];
            r_sda_q     <= w_filt[1];
            r_scl_rise  <= w_filt[0] & ~r_scl_q;
            r_scl_fall  <= ~w_filt[0] & r_scl_q;
            r_start_det <= w_start;
            r_stop_det  <= w_stop;
            if (w_start) begin
                r_bus_busy <= 1'b1;
            end else if (w_stop) begin
                r_bus_busy <= 1'b0;
            end
        end
    end

    assign scl_o     = w_filt[0];
    assign sda_o     = w_filt[1];
    assign scl_rise  = r_scl_rise;
    assign scl_fall  = r_scl_fall;
    assign start_det = r_start_det;
    assign stop_det  = r_stop_det;
    assign bus_busy  = r_bus_busy;

endmodule
